safety_island_boot_ctrl_regs: RTL and testbench
===============================================

// Module: safety_island_boot_ctrl_regs
// PURPOSE
//  AXI4-Lite responder for the safety-island boot/control registers, sitting behind the
//  external AXI slave port. Serves the host boot sequence: bootmode select, entry point,
//  fetch enable and EOC polling. Drives core boot address, bootmode and fetch enable.
//  The core writes end-of-computation and the exit code into STATUS via the same port.
// PARAMETERS
//  AddrWidth        32            AXI-Lite address width; only addr[4:2] decoded
//  BootAddrDefault  32'h1C00_0080 BOOT_ADDR reset value
//  BootModeDefault  2'd0          BOOTMODE reset value
// PORTS
//  clk_i          in   1   clock
//  rst_ni         in   1   asynchronous reset, active low
//  awaddr_i       in   AW  write address;  awvalid_i in 1; awready_o out 1
//  wdata_i        in   32  write data;     wstrb_i in 4; wvalid_i in 1; wready_o out 1
//  bresp_o        out  2   write response; bvalid_o out 1; bready_i in 1
//  araddr_i       in   AW  read address;   arvalid_i in 1; arready_o out 1
//  rdata_o        out  32  read data;      rresp_o out 2; rvalid_o out 1; rready_i in 1
//  bootmode_o     out  2   BOOTMODE[1:0]
//  boot_addr_o    out  32  BOOT_ADDR
//  fetch_en_o     out  1   FETCH_EN[0]
//  eoc_o          out  1   STATUS[31]
//  exit_status_o  out  31  STATUS[30:0]
// BEHAVIOUR
//  Map (addr[4:2]): 0 BOOTMODE rw[1:0]; 1 BOOT_ADDR rw[31:0]; 2 FETCH_EN rw[0];
//   3 STATUS rw[31:0]; 4-7 unmapped. Unused bits read 0, writes ignored.
//  Reset: bootmode_o=BootModeDefault, boot_addr_o=BootAddrDefault, fetch_en_o=0,
//   STATUS=0, all ready/valid outputs 0 during reset; ready=1 first cycle after release.
//  Write FSM: W_IDLE -> (AW and/or W latched) -> W_RESP.
//   awready_o=1 while no AW latched and not in W_RESP; wready_o likewise for W.
//   AW and W accepted independently, any order, same cycle allowed.
//   Edge where both are held: register updated, bvalid_o=1 from next cycle (1-cycle latency
//   from the later of AW/W handshake). bvalid/bresp stable until bready_i; then W_IDLE.
//   Byte strobes honoured per byte; wstrb=0 -> no change, OKAY.
//  Read FSM: R_IDLE (arready_o=1) -> AR handshake samples register -> R_RESP:
//   rvalid_o=1 next cycle, rdata/rresp stable until rready_i; arready_o=0 in R_RESP.
//  Read and write FSMs independent; read and write same register committing on same edge:
//   read returns pre-write value.
//  Unmapped address: write dropped, bresp=SLVERR(2'b10); read rdata=0, rresp=SLVERR.
//   Mapped: OKAY(2'b00).
//  No bursts/IDs; at most one outstanding write and one read.
//  Outputs are direct register flops (no comb path from bus inputs).
//  fetch_en_o is level: stays 1 until software clears it. STATUS not cleared by hardware.
//  Async reset mid-transaction: drop pending AW/W/AR, deassert bvalid/rvalid immediately,
//   registers return to reset values.
// TESTING
//  1 Reset: check bootmode_o=0, boot_addr_o=32'h1C00_0080, fetch_en_o=0, eoc_o=0,
//    bvalid_o=rvalid_o=0; read all 4 regs -> reset values, OKAY.
//  2 Boot sequence: write BOOTMODE=1, BOOT_ADDR=32'h1C00_8080, FETCH_EN=1 ->
//    outputs update on commit edge, bvalid 1 cycle after, bresp=OKAY.
//  3 AW 3 cycles before W, then W before AW, then both same cycle with bready held low 5
//    cycles -> bvalid held, no second AW accepted until B completes.
//  4 Strobes: BOOT_ADDR=0, write 32'hAABBCCDD wstrb=4'b0101 -> reads 32'h00BB00DD.
//  5 EOC: write STATUS=32'h8000_0000 | 31'd42 -> eoc_o=1, exit_status_o=42; poll read returns
//    same; write to 0x14 -> SLVERR, read 0x1C -> rdata=0, SLVERR.
//  6 Read/write same edge on BOOT_ADDR; rready low 4 cycles; assert rst_ni low mid-B ->
//    old value returned, rdata stable while stalled, bvalid/rvalid drop at once on reset.

Source files
------------

// File: rtl/safety_island_boot_ctrl_regs.sv
// safety_island_boot_ctrl_regs
//   AXI4-Lite responder for the safety-island boot/control registers.
//   Register map (addr[4:2]):
//     0 BOOTMODE  [1:0]  rw
//     1 BOOT_ADDR [31:0] rw
//     2 FETCH_EN  [0]    rw
//     3 STATUS    [31:0] rw  (bit 31 = end of computation, [30:0] = exit code)
//     4-7 unmapped       (write dropped / read 0, SLVERR)
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   aw*/w*/b*                         AXI4-Lite write address, data, response channels
//   ar*/r*                            AXI4-Lite read address and data channels
//   bootmode_o, boot_addr_o,
//   fetch_en_o, eoc_o, exit_status_o  register contents driven to the core
module safety_island_boot_ctrl_regs #(
    parameter int unsigned AddrWidth       = 32,
    parameter logic [31:0] BootAddrDefault = 32'h1C00_0080,
    parameter logic [1:0]  BootModeDefault = 2'd0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] awaddr_i,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           wstrb_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    input  logic [AddrWidth-1:0] araddr_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    output logic [31:0]          rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [1:0]           bootmode_o,
    output logic [31:0]          boot_addr_o,
    output logic                 fetch_en_o,
    output logic                 eoc_o,
    output logic [30:0]          exit_status_o
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t     wstate;
    rstate_t     rstate;

    logic [1:0]  bootmode_q;
    logic [31:0] boot_addr_q;
    logic        fetch_en_q;
    logic [31:0] status_q;

    logic        awready_q, wready_q, aw_held, w_held;
    logic [2:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, aw_have, w_have;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, wr_cur, wr_merged, rd_val;
    logic [3:0]  wr_strb;
    logic [31:0] reg_view [4];

    // Only addr[4:2] is decoded; the remaining address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr_i[AddrWidth-1:5], awaddr_i[1:0],
                                araddr_i[AddrWidth-1:5], araddr_i[1:0]};

    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        reg_view[0] = {30'd0, bootmode_q};
        reg_view[1] = boot_addr_q;
        reg_view[2] = {31'd0, fetch_en_q};
        reg_view[3] = status_q;
    end

    // A channel counts as "had" if it was latched earlier or handshakes on this edge,
    // so AW and W may complete in either order or together.
    always_comb begin
        aw_hs     = awvalid_i && awready_q;
        w_hs      = wvalid_i && wready_q;
        aw_have   = aw_held || aw_hs;
        w_have    = w_held || w_hs;
        wr_idx    = aw_held ? waddr_q : awaddr_i[4:2];
        wr_data   = w_held ? wdata_q : wdata_i;
        wr_strb   = w_held ? wstrb_q : wstrb_i;
        wr_cur    = wr_idx[2] ? 32'd0 : reg_view[wr_idx[1:0]];
        wr_merged = strb_merge(wr_cur, wr_data, wr_strb);
        rd_idx    = araddr_i[4:2];
        rd_val    = rd_idx[2] ? 32'd0 : reg_view[rd_idx[1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate      <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RespOkay;
            bootmode_q  <= BootModeDefault;
            boot_addr_q <= BootAddrDefault;
            fetch_en_q  <= 1'b0;
            status_q    <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_have && w_have) begin
                        wstate    <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_idx[2] ? RespSlverr : RespOkay;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (!wr_idx[2]) begin
                            case (wr_idx[1:0])
                                2'd0:    bootmode_q  <= wr_merged[1:0];
                                2'd1:    boot_addr_q <= wr_merged;
                                2'd2:    fetch_en_q  <= wr_merged[0];
                                default: status_q    <= wr_merged;
                            endcase
                        end
                    end else begin
                        aw_held   <= aw_have;
                        w_held    <= w_have;
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                        if (aw_hs) waddr_q <= awaddr_i[4:2];
                        if (w_hs) begin
                            wdata_q <= wdata_i;
                            wstrb_q <= wstrb_i;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        wstate    <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // The read samples register state before this edge's write commits,
    // so a same-edge read/write on one register returns the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid_i && arready_q) begin
                        rstate    <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_val;
                        rresp_q   <= rd_idx[2] ? RespSlverr : RespOkay;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready_i) begin
                        rstate    <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign awready_o     = awready_q;
    assign wready_o      = wready_q;
    assign bvalid_o      = bvalid_q;
    assign bresp_o       = bresp_q;
    assign arready_o     = arready_q;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign rresp_o       = rresp_q;
    assign bootmode_o    = bootmode_q;
    assign boot_addr_o   = boot_addr_q;
    assign fetch_en_o    = fetch_en_q;
    assign eoc_o         = status_q[31];
    assign exit_status_o = status_q[30:0];

endmodule

// File: tb/tb_safety_island_boot_ctrl_regs.sv
// tb_safety_island_boot_ctrl_regs
//   Directed bench for safety_island_boot_ctrl_regs. Stimulus tasks push the expected
//   B / R responses into queues; a monitor compares them whenever a response handshakes.
module tb_safety_island_boot_ctrl_regs;

    localparam logic [31:0] A_BOOTMODE  = 32'h00;
    localparam logic [31:0] A_BOOT_ADDR = 32'h04;
    localparam logic [31:0] A_FETCH_EN  = 32'h08;
    localparam logic [31:0] A_STATUS    = 32'h0C;
    localparam logic [1:0]  OKAY        = 2'b00;
    localparam logic [1:0]  SLVERR      = 2'b10;
    localparam int          Budget      = 50;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] awaddr_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b1;
    logic [31:0] araddr_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i = 1'b1;
    logic [1:0]  bootmode_o;
    logic [31:0] boot_addr_o;
    logic        fetch_en_o;
    logic        eoc_o;
    logic [30:0] exit_status_o;

    int checks = 0;
    int errors = 0;

    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    safety_island_boot_ctrl_regs #(
        .AddrWidth      (32),
        .BootAddrDefault(32'h1C00_0080),
        .BootModeDefault(2'd0)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .awaddr_i     (awaddr_i),
        .awvalid_i    (awvalid_i),
        .awready_o    (awready_o),
        .wdata_i      (wdata_i),
        .wstrb_i      (wstrb_i),
        .wvalid_i     (wvalid_i),
        .wready_o     (wready_o),
        .bresp_o      (bresp_o),
        .bvalid_o     (bvalid_o),
        .bready_i     (bready_i),
        .araddr_i     (araddr_i),
        .arvalid_i    (arvalid_i),
        .arready_o    (arready_o),
        .rdata_o      (rdata_o),
        .rresp_o      (rresp_o),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .bootmode_o   (bootmode_o),
        .boot_addr_o  (boot_addr_o),
        .fetch_en_o   (fetch_en_o),
        .eoc_o        (eoc_o),
        .exit_status_o(exit_status_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Response monitor: the handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (bvalid_o && bready_i) begin
                if (b_q.size() == 0) begin
                    timeout("b_unexpected");
                end else begin
                    logic [1:0] eb;
                    eb = b_q.pop_front();
                    check("bresp", {30'd0, bresp_o}, {30'd0, eb});
                end
            end
            if (rvalid_o && rready_i) begin
                if (r_q.size() == 0) begin
                    timeout("r_unexpected");
                end else begin
                    logic [33:0] er;
                    er = r_q.pop_front();
                    check("rdata", rdata_o, er[33:2]);
                    check("rresp", {30'd0, rresp_o}, {30'd0, er[1:0]});
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input logic [1:0] exp_resp);
        b_q.push_back(exp_resp);
        fork
            begin
                int n;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr_i = addr; awvalid_i = 1'b1; n = 0;
                do begin @(negedge clk); n++; end while (!awready_o && n < Budget);
                if (!awready_o) timeout("aw_handshake");
                @(posedge clk); #1; awvalid_i = 1'b0;
            end
            begin
                int m;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata_i = data; wstrb_i = strb; wvalid_i = 1'b1; m = 0;
                do begin @(negedge clk); m++; end while (!wready_o && m < Budget);
                if (!wready_o) timeout("w_handshake");
                @(posedge clk); #1; wvalid_i = 1'b0;
            end
        join
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        int n;
        r_q.push_back({exp_data, exp_resp});
        araddr_i = addr; arvalid_i = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!arready_o && n < Budget);
        if (!arready_o) timeout("ar_handshake");
        @(posedge clk); #1; arvalid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while ((b_q.size() != 0 || r_q.size() != 0) && n < Budget);
        if (b_q.size() != 0 || r_q.size() != 0) begin
            timeout("response_drain");
            b_q.delete();
            r_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'd0, awready_o}, 32'd0);
        check("rst_arready", {31'd0, arready_o}, 32'd0);
        check("rst_bootmode", {30'd0, bootmode_o}, 32'd0);
        check("rst_boot_addr", boot_addr_o, 32'h1C00_0080);
        check("rst_fetch_en", {31'd0, fetch_en_o}, 32'd0);
        check("rst_eoc", {31'd0, eoc_o}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid_o}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("rel_awready", {31'd0, awready_o}, 32'd1);
        check("rel_wready", {31'd0, wready_o}, 32'd1);
        check("rel_arready", {31'd0, arready_o}, 32'd1);
        axi_read(A_BOOTMODE, 32'd0, OKAY);           wait_idle();
        axi_read(A_BOOT_ADDR, 32'h1C00_0080, OKAY);  wait_idle();
        axi_read(A_FETCH_EN, 32'd0, OKAY);           wait_idle();
        axi_read(A_STATUS, 32'd0, OKAY);             wait_idle();

        // 2: boot sequence
        axi_write(A_BOOTMODE, 32'd1, 4'hF, 0, 0, OKAY);
        check("boot_bootmode", {30'd0, bootmode_o}, 32'd1);
        check("boot_bvalid", {31'd0, bvalid_o}, 32'd1);
        wait_idle();
        axi_write(A_BOOT_ADDR, 32'h1C00_8080, 4'hF, 0, 0, OKAY);
        check("boot_boot_addr", boot_addr_o, 32'h1C00_8080);
        wait_idle();
        axi_write(A_FETCH_EN, 32'd1, 4'hF, 0, 0, OKAY);
        check("boot_fetch_en", {31'd0, fetch_en_o}, 32'd1);
        wait_idle();

        // 3: AW before W, W before AW, both together with B stalled
        fork
            axi_write(A_BOOTMODE, 32'd2, 4'hF, 0, 3, OKAY);
            begin
                @(posedge clk); #1;
                check("awfirst_awready", {31'd0, awready_o}, 32'd0);
                check("awfirst_wready", {31'd0, wready_o}, 32'd1);
                check("awfirst_bvalid", {31'd0, bvalid_o}, 32'd0);
                check("awfirst_bootmode", {30'd0, bootmode_o}, 32'd1);
            end
        join
        check("awfirst_commit", {30'd0, bootmode_o}, 32'd2);
        wait_idle();
        axi_write(A_BOOT_ADDR, 32'h1C00_1000, 4'hF, 2, 0, OKAY);
        check("wfirst_commit", boot_addr_o, 32'h1C00_1000);
        wait_idle();
        bready_i = 1'b0;
        axi_write(A_FETCH_EN, 32'd0, 4'hF, 0, 0, OKAY);
        check("same_fetch_en", {31'd0, fetch_en_o}, 32'd0);
        awaddr_i = A_BOOTMODE; awvalid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_bvalid", {31'd0, bvalid_o}, 32'd1);
            check("stall_bresp", {30'd0, bresp_o}, {30'd0, OKAY});
            check("stall_awready", {31'd0, awready_o}, 32'd0);
        end
        @(posedge clk); #1;
        awvalid_i = 1'b0;
        bready_i = 1'b1;
        wait_idle();

        // 4: byte strobes
        axi_write(A_BOOT_ADDR, 32'd0, 4'hF, 0, 0, OKAY);          wait_idle();
        axi_write(A_BOOT_ADDR, 32'hAABB_CCDD, 4'b0101, 0, 0, OKAY); wait_idle();
        check("strb_boot_addr", boot_addr_o, 32'h00BB_00DD);
        axi_read(A_BOOT_ADDR, 32'h00BB_00DD, OKAY);                wait_idle();
        axi_write(A_BOOTMODE, 32'd3, 4'h0, 0, 0, OKAY);             wait_idle();
        check("strb0_bootmode", {30'd0, bootmode_o}, 32'd2);

        // 5: EOC and unmapped accesses
        axi_write(A_STATUS, 32'h8000_002A, 4'hF, 0, 0, OKAY);       wait_idle();
        check("eoc", {31'd0, eoc_o}, 32'd1);
        check("exit_status", {1'b0, exit_status_o}, 32'd42);
        axi_read(A_STATUS, 32'h8000_002A, OKAY);                   wait_idle();
        axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, SLVERR);       wait_idle();
        check("unmapped_wr_status", {31'd0, eoc_o}, 32'd1);
        axi_read(32'h1C, 32'd0, SLVERR);                           wait_idle();

        // 6: same-edge read/write, read stall, reset mid-response
        bready_i = 1'b0;
        rready_i = 1'b0;
        check("pre_awready", {31'd0, awready_o}, 32'd1);
        check("pre_arready", {31'd0, arready_o}, 32'd1);
        b_q.push_back(OKAY);
        r_q.push_back({32'h00BB_00DD, OKAY});
        awaddr_i = A_BOOT_ADDR; wdata_i = 32'h1234_5678; wstrb_i = 4'hF;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        araddr_i = A_BOOT_ADDR; arvalid_i = 1'b1;
        @(posedge clk); #1;
        awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
        check("rw_boot_addr", boot_addr_o, 32'h1234_5678);
        check("rw_bvalid", {31'd0, bvalid_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstall_rvalid", {31'd0, rvalid_o}, 32'd1);
            check("rstall_rdata", rdata_o, 32'h00BB_00DD);
        end
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        check("arst_bvalid", {31'd0, bvalid_o}, 32'd0);
        check("arst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("arst_boot_addr", boot_addr_o, 32'h1C00_0080);
        check("arst_bootmode", {30'd0, bootmode_o}, 32'd0);
        check("arst_eoc", {31'd0, eoc_o}, 32'd0);
        b_q.delete();
        r_q.delete();
        bready_i = 1'b1;
        rready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_awready", {31'd0, awready_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("rel2_awready", {31'd0, awready_o}, 32'd1);
        check("rel2_arready", {31'd0, arready_o}, 32'd1);
        axi_read(A_BOOT_ADDR, 32'h1C00_0080, OKAY);  wait_idle();
        axi_read(A_STATUS, 32'd0, OKAY);             wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
